// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector: compares the most recent len
// accepted bits against a loadable pattern and counts matches (saturating).
module seq_detector_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0000_1010),
  parameter int                 RST_LEN     = 4,
  parameter bit                 RST_OVERLAP = 1'b1,
  parameter int                 LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               clr_count,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Only MAX_LEN-1 previous bits are stored: with the incoming bit that gives
  // the full MAX_LEN window, and anything older can never be compared.
  logic [MAX_LEN-2:0] hist_reg;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_reg;
  logic [LEN_W-1:0]   fill_next;
  logic [MAX_LEN-1:0] pattern_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               overlap_reg;
  logic               detected_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               cfg_err_reg;

  logic [MAX_LEN-1:0] len_mask;
  logic               accept;
  logic               match;
  logic               cfg_ok;

  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign len_mask[gi] = (LEN_W'(gi) < len_reg);
    end
  endgenerate

  always_comb begin
    accept    = in_valid && !cfg_we;
    hist_next = {hist_reg, in_bit};
    fill_next = (fill_reg == MAX_LEN_W) ? fill_reg : fill_reg + LEN_W'(1);
    match     = accept && (fill_next >= len_reg) &&
                (((hist_next ^ pattern_reg) & len_mask) == '0);
    cfg_ok    = (cfg_len != '0) && (cfg_len <= MAX_LEN_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_reg     <= '0;
      fill_reg     <= '0;
      pattern_reg  <= RST_PATTERN;
      len_reg      <= LEN_W'(RST_LEN);
      overlap_reg  <= RST_OVERLAP;
      detected_reg <= 1'b0;
      count_reg    <= '0;
      cfg_err_reg  <= 1'b0;
    end else begin
      detected_reg <= match;

      if (cfg_we) begin
        // A rejected write still flushes history so partial matches never
        // straddle a configuration attempt.
        hist_reg <= '0;
        fill_reg <= '0;
        if (cfg_ok) begin
          pattern_reg <= cfg_pattern;
          len_reg     <= cfg_len;
          overlap_reg <= cfg_overlap;
          cfg_err_reg <= 1'b0;
        end else begin
          cfg_err_reg <= 1'b1;
        end
      end else if (in_valid) begin
        hist_reg <= hist_next[MAX_LEN-2:0];
        fill_reg <= (match && !overlap_reg) ? '0 : fill_next;
      end

      if (clr_count) begin
        count_reg <= '0;
      end else if (match && (count_reg != CNT_MAX)) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  assign detected    = detected_reg;
  assign match_count = count_reg;
  assign cfg_err     = cfg_err_reg;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Bench for seq_detector_prog: queue-based reference model checked every cycle,
// plus literal pulse/count expectations per directed scenario.
module tb_seq_detector_prog;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;
  localparam int LEN_W   = 4;
  localparam int CNT_SAT = 15;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               in_bit;
  logic               clr_count;
  logic               detected;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  // Reference model state: bits received since the last flush, newest last.
  bit         q[$];
  logic [7:0] m_pat   = 8'b0000_1010;
  int         m_len   = 4;
  bit         m_ov    = 1'b1;
  bit         exp_det = 1'b0;
  int         exp_cnt = 0;
  bit         exp_err = 1'b0;

  seq_detector_prog #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .clr_count  (clr_count),
    .detected   (detected),
    .match_count(match_count),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: matching is "the last len received bits spell the pattern".
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete();
      m_pat   = 8'b0000_1010;
      m_len   = 4;
      m_ov    = 1'b1;
      exp_det = 1'b0;
      exp_cnt = 0;
      exp_err = 1'b0;
    end else begin : model_step
      bit hit;
      hit = 1'b0;
      if (cfg_we) begin
        q.delete();
        if (int'(cfg_len) >= 1 && int'(cfg_len) <= MAX_LEN) begin
          m_pat   = cfg_pattern;
          m_len   = int'(cfg_len);
          m_ov    = cfg_overlap;
          exp_err = 1'b0;
        end else begin
          exp_err = 1'b1;
        end
      end else if (in_valid) begin
        q.push_back(in_bit);
        if (q.size() > MAX_LEN) void'(q.pop_front());
        if (q.size() >= m_len) begin
          hit = 1'b1;
          for (int k = 0; k < m_len; k++)
            if (q[q.size() - 1 - k] != m_pat[k]) hit = 1'b0;
        end
        if (hit && !m_ov) q.delete();
      end
      exp_det = hit;
      if (clr_count) exp_cnt = 0;
      else if (hit) exp_cnt = (exp_cnt + 1 > CNT_SAT) ? CNT_SAT : exp_cnt + 1;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("detected", int'(detected), int'(exp_det));
    chk("match_count", int'(match_count), exp_cnt);
    chk("cfg_err", int'(cfg_err), int'(exp_err));
    if (detected) pulses++;
  end

  task automatic idle_inputs();
    cfg_we    = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    clr_count = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic send(input bit b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
  endtask

  // Sends the low n bits of v MSB-first, optionally with an idle cycle after each.
  task automatic send_bits(input logic [63:0] v, input int n, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      send(v[i]);
      if (gap) tick();
    end
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input bit ov);
    cfg_we      = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ov;
    tick();
  endtask

  initial begin
    idle_inputs();
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_detected", int'(detected), 0);
    chk("rst_count", int'(match_count), 0);
    chk("rst_err", int'(cfg_err), 0);
    rst = 1'b0;

    // Default 1010 overlapping
    pulses = 0;
    send_bits(64'b101010, 6, 1'b0);
    tick();
    chk("t1_pulses", pulses, 2);
    chk("t1_count", int'(match_count), 2);
    chk("t1_model_count", exp_cnt, 2);

    // Non-overlapping 1010
    cfg(8'h0A, 4'd4, 1'b0);
    pulses = 0;
    send_bits(64'b10101010, 8, 1'b0);
    tick();
    chk("t2_pulses", pulses, 2);
    chk("t2_count", int'(match_count), 4);
    clr_count = 1'b1;
    tick();
    tick();
    chk("t2_clr", int'(match_count), 0);

    // Full-length A5 with idle gaps between accepted bits
    cfg(8'hA5, 4'd8, 1'b1);
    pulses = 0;
    send_bits(64'hA5, 8, 1'b1);
    tick();
    chk("t3_pulses", pulses, 1);
    chk("t3_count", int'(match_count), 1);

    // Rejected configs keep 1010/4
    cfg(8'h0A, 4'd4, 1'b1);
    cfg(8'hFF, 4'd0, 1'b0);
    tick();
    chk("t4_err_len0", int'(cfg_err), 1);
    cfg(8'hFF, 4'd9, 1'b0);
    tick();
    chk("t4_err_len9", int'(cfg_err), 1);
    pulses = 0;
    send_bits(64'b1010, 4, 1'b0);
    tick();
    chk("t4_pulses", pulses, 1);
    chk("t4_count", int'(match_count), 2);
    cfg(8'h0A, 4'd4, 1'b1);
    tick();
    chk("t4_err_clear", int'(cfg_err), 0);

    // Saturation and clear-wins
    clr_count = 1'b1;
    tick();
    pulses = 0;
    for (int i = 0; i < 18; i++) begin
      send(1'b1);
      send(1'b0);
    end
    tick();
    chk("t5_pulses", pulses, 17);
    chk("t5_sat", int'(match_count), CNT_SAT);
    chk("t5_model_sat", exp_cnt, CNT_SAT);
    send(1'b1);
    in_valid  = 1'b1;
    in_bit    = 1'b0;
    clr_count = 1'b1;
    tick();
    chk("t5_clr_det", int'(detected), 1);
    chk("t5_clr_count", int'(match_count), 0);

    // Reset mid-stream discards history
    send_bits(64'b101, 3, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    pulses = 0;
    send(1'b0);
    tick();
    chk("t6_no_pulse", pulses, 0);
    send_bits(64'b1010, 4, 1'b0);
    tick();
    chk("t6_pulses", pulses, 1);
    chk("t6_count", int'(match_count), 1);

    // cfg_we wins over in_valid: the concurrent 1 must be dropped
    cfg_we      = 1'b1;
    cfg_pattern = 8'h0A;
    cfg_len     = 4'd4;
    cfg_overlap = 1'b1;
    in_valid    = 1'b1;
    in_bit      = 1'b1;
    tick();
    pulses = 0;
    send_bits(64'b010, 3, 1'b0);
    tick();
    chk("t7_dropped_bit", pulses, 0);
    chk("t7_count", int'(match_count), 1);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
